// File: rtl/countervar_pkg.sv
// Shared types, constants and helpers for the countervar loadable down-counter.
package countervar_pkg;

   // Counter lifecycle: idle after reset, armed by a non-zero load,
   // running once the first decrement happens, done after a stop at zero.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Default count width used when the instantiating level does not override it.
   localparam int DEFAULT_WIDTH = 4;

   // Widest count the parity helper is able to fold.
   localparam int PARITY_MAX_WIDTH = 64;

   // Parity of a count value; narrower counts are zero-extended by the caller,
   // which leaves the XOR reduction unchanged.
   function automatic logic parity(input logic [PARITY_MAX_WIDTH-1:0] value);
      return ^value;
   endfunction

endpackage : countervar_pkg

// File: rtl/countervar_load_edge.sv
// Falling-edge detector for the active-low load strobe. A strobe held low
// produces a single event; the history flop restarts at 1 so that a strobe
// already low when reset releases is still seen as a fresh load.
module countervar_load_edge (
   input  logic clk_50,
   input  logic reset,
   input  logic load_1,
   output logic load_evt
);

   logic load_hist;

   // Remember the strobe level seen on the previous rising edge.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         load_hist <= 1'b1;
      end else begin
         load_hist <= load_1;
      end
   end

   // The event is visible in the same cycle the strobe is first low, so the
   // consumer captures count_in on the very edge that samples the strobe.
   assign load_evt = load_hist & ~load_1;

endmodule : countervar_load_edge

// File: rtl/countervar_loadable.sv
// Loadable down-counter: captures a value on a load strobe, counts it down
// while enabled, pulses done at terminal and either stops at zero or reloads
// the captured value and keeps running.
module countervar_loadable
   import countervar_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             load_1,
   input  logic [WIDTH-1:0] count_in,
   input  logic             enable,
   output logic [WIDTH-1:0] count_out,
   output logic             load_ack,
   output logic             done,
   output logic             busy,
   output logic             parity_out
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_next;
   logic             load_ack_next;
   logic             done_next;
   logic             load_evt;

   countervar_load_edge u_load_edge (
      .clk_50   (clk_50),
      .reset    (reset),
      .load_1   (load_1),
      .load_evt (load_evt)
   );

   // Register the FSM state together with the count, the reload copy and the
   // two single-cycle status pulses; reset wins over everything.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         state      <= ST_IDLE;
         count_out  <= ZERO;
         reload_reg <= ZERO;
         load_ack   <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         count_out  <= count_next;
         reload_reg <= reload_next;
         load_ack   <= load_ack_next;
         done       <= done_next;
      end
   end

   // Next-state and datapath decisions. A load always beats counting, which
   // is what suppresses done when a load lands on the terminal edge. The
   // count is never below one while armed or running, so the terminal branch
   // is the only way to reach zero and the decrement cannot wrap.
   always_comb begin
      state_next    = state;
      count_next    = count_out;
      reload_next   = reload_reg;
      load_ack_next = 1'b0;
      done_next     = 1'b0;

      if (load_evt) begin
         count_next    = count_in;
         reload_next   = count_in;
         load_ack_next = 1'b1;
         state_next    = (count_in != ZERO) ? ST_ARMED : ST_IDLE;
      end else begin
         case (state)
            ST_ARMED, ST_RUN: begin
               if (enable) begin
                  if (count_out > ONE) begin
                     count_next = count_out - ONE;
                     state_next = ST_RUN;
                  end else begin
                     done_next = 1'b1;
                     if (AUTO_RELOAD) begin
                        count_next = reload_reg;
                        state_next = ST_RUN;
                     end else begin
                        count_next = ZERO;
                        state_next = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               count_next = ZERO;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = (state == ST_ARMED) || (state == ST_RUN);
   assign parity_out = parity(PARITY_MAX_WIDTH'(count_out));

endmodule : countervar_loadable

// File: tb/tb_countervar_loadable.sv
// Bench for countervar_loadable: one stop-at-zero and one auto-reload
// instance share the same stimulus and are each tracked by a behavioural
// model that follows the counter's rules in plain arithmetic.
module tb_countervar_loadable;

   localparam int W = 4;

   logic         clk_50 = 1'b0;
   logic         reset = 1'b1;
   logic         load_1 = 1'b1;
   logic [W-1:0] count_in = '0;
   logic         enable = 1'b0;

   logic [W-1:0] count_stop, count_auto;
   logic         ack_stop, ack_auto;
   logic         done_stop, done_auto;
   logic         busy_stop, busy_auto;
   logic         par_stop, par_auto;

   int checks = 0;
   int failures = 0;

   // Model state: index 0 = stop-at-zero instance, index 1 = auto-reload.
   int m_count[2];
   int m_reload[2];
   bit m_active[2];
   bit m_ack[2];
   bit m_done[2];
   bit m_prev_load;

   countervar_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_stop (
      .clk_50     (clk_50),
      .reset      (reset),
      .load_1     (load_1),
      .count_in   (count_in),
      .enable     (enable),
      .count_out  (count_stop),
      .load_ack   (ack_stop),
      .done       (done_stop),
      .busy       (busy_stop),
      .parity_out (par_stop)
   );

   countervar_loadable #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_auto (
      .clk_50     (clk_50),
      .reset      (reset),
      .load_1     (load_1),
      .count_in   (count_in),
      .enable     (enable),
      .count_out  (count_auto),
      .load_ack   (ack_auto),
      .done       (done_auto),
      .busy       (busy_auto),
      .parity_out (par_auto)
   );

   // 50 MHz system clock.
   always #10 clk_50 = ~clk_50;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance both models by one rising edge using the inputs about to be sampled.
   task automatic modelStep(input bit r, input bit l, input int c, input bit e);
      bit evt;
      evt = m_prev_load && !l;
      m_prev_load = r ? 1'b1 : l;
      for (int i = 0; i < 2; i++) begin
         m_ack[i]  = 1'b0;
         m_done[i] = 1'b0;
         if (r) begin
            m_count[i]  = 0;
            m_reload[i] = 0;
            m_active[i] = 1'b0;
         end else if (evt) begin
            m_count[i]  = c;
            m_reload[i] = c;
            m_ack[i]    = 1'b1;
            m_active[i] = (c != 0);
         end else if (m_active[i] && e) begin
            if (m_count[i] > 1) begin
               m_count[i] = m_count[i] - 1;
            end else begin
               m_done[i] = 1'b1;
               if (i == 1) begin
                  m_count[i] = m_reload[i];
               end else begin
                  m_count[i]  = 0;
                  m_active[i] = 1'b0;
               end
            end
         end
      end
   endtask

   function automatic bit oddBits(input int v);
      bit p;
      p = 1'b0;
      for (int b = 0; b < W; b++) p ^= v[b];
      return p;
   endfunction

   // Drive one cycle of inputs away from the active edge, step the models,
   // then compare every output of both instances on the falling edge.
   task automatic applyStimulus(input bit r, input bit l, input int c, input bit e);
      reset    = r;
      load_1   = l;
      count_in = W'(c);
      enable   = e;
      modelStep(r, l, c, e);
      @(posedge clk_50);
      @(negedge clk_50);
      checkOutput("stop_count",  32'(count_stop), 32'(m_count[0]));
      checkOutput("stop_ack",    32'(ack_stop),   32'(m_ack[0]));
      checkOutput("stop_done",   32'(done_stop),  32'(m_done[0]));
      checkOutput("stop_busy",   32'(busy_stop),  32'(m_active[0]));
      checkOutput("stop_parity", 32'(par_stop),   32'(oddBits(m_count[0])));
      checkOutput("auto_count",  32'(count_auto), 32'(m_count[1]));
      checkOutput("auto_ack",    32'(ack_auto),   32'(m_ack[1]));
      checkOutput("auto_done",   32'(done_auto),  32'(m_done[1]));
      checkOutput("auto_busy",   32'(busy_auto),  32'(m_active[1]));
      checkOutput("auto_parity", 32'(par_auto),   32'(oddBits(m_count[1])));
   endtask

   initial begin
      int ack_pulses;
      bit r, l, e;
      int c;

      m_prev_load = 1'b1;
      @(negedge clk_50);

      // Reset held two cycles with the strobe low and enable high.
      applyStimulus(1, 0, 4'h6, 1);
      applyStimulus(1, 0, 4'h6, 1);
      checkOutput("reset_count", 32'(count_stop), 32'd0);
      checkOutput("reset_busy",  32'(busy_auto),  32'd0);
      applyStimulus(0, 1, 0, 1);

      // Load 0xA while paused, then hold.
      applyStimulus(0, 0, 4'hA, 0);
      checkOutput("load_a_count", 32'(count_stop), 32'hA);
      checkOutput("load_a_ack",   32'(ack_stop),   32'd1);
      checkOutput("load_a_par",   32'(par_stop),   32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
      checkOutput("pause_a_count", 32'(count_auto), 32'hA);

      // Load 3 and run to terminal, then sit for ten cycles.
      applyStimulus(0, 0, 3, 1);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(0, 1, 0, 1);
      checkOutput("term_done", 32'(done_stop), 32'd1);
      checkOutput("term_zero", 32'(count_stop), 32'd0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 1);
      checkOutput("stop_hold", 32'(count_stop), 32'd0);

      // Strobe held low for five cycles yields a single acknowledge.
      ack_pulses = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 5, 0);
         if (ack_stop) ack_pulses++;
      end
      checkOutput("held_acks", 32'(ack_pulses), 32'd1);
      applyStimulus(0, 1, 0, 0);

      // Count down to 5, reload 9 mid-count, pause, then reset mid-run.
      applyStimulus(0, 0, 8, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1);
      checkOutput("mid_at5", 32'(count_stop), 32'd5);
      applyStimulus(0, 0, 9, 1);
      checkOutput("mid_reload", 32'(count_stop), 32'd9);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(1, 1, 0, 1);
      checkOutput("mid_reset_busy", 32'(busy_stop), 32'd0);
      applyStimulus(0, 1, 0, 1);

      // Auto-reload with value 2, then a load landing on a terminal edge.
      applyStimulus(0, 0, 2, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1);
      checkOutput("auto_at1", 32'(count_auto), 32'd1);
      applyStimulus(0, 0, 7, 1);
      checkOutput("coinc_count", 32'(count_auto), 32'd7);
      checkOutput("coinc_done",  32'(done_auto),  32'd0);
      applyStimulus(0, 1, 0, 1);

      // Randomized traffic against the models.
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(63) == 0);
         l = ($urandom_range(7) != 0) ? 1'b1 : ($urandom_range(1) == 1 ? 1'b0 : load_1);
         c = $urandom_range(15);
         e = ($urandom_range(3) != 0);
         applyStimulus(r, l, c, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_countervar_loadable

// File: doc/countervar_loadable.md
Name: countervar_loadable

Overview:
- Loadable down-counter that accepts the active-low load strobe and load value driven by the bench `load_count` task (`load_1`, `count_in`).
- Counts a loaded value down to terminal, flags completion, and optionally auto-reloads.
- Sits as the DUT-side responder of the countervar load interface, clocked by the 50 MHz system clock.

Parameters:
WIDTH, 4, bit width of `count_in`, `count_out` and the reload register
AUTO_RELOAD, 0, 1 = reload the captured value at terminal and keep running; 0 = stop at zero

Ports:
clk_50  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
load_1  input  1  active-low load strobe from initiator
count_in  input  WIDTH  load value, sampled on accepted load
enable  input  1  count enable; low = pause
count_out  output  WIDTH  current count (registered)
load_ack  output  1  one-cycle pulse, load accepted
done  output  1  one-cycle pulse, terminal reached
busy  output  1  high while ARMED or RUN
parity_out  output  1  XOR of all `count_out` bits (combinational from `count_out`)

Behaviour:
- Reset (synchronous, active-high, sampled on `clk_50` rising edge):
  - `count_out`=0, `reload_reg`=0, `load_ack`=0, `done`=0, state=IDLE, `busy`=0, `parity_out`=0.
  - Internal `load_1` history flop is set to 1.
  - Reset overrides every other input, mid-operation included.
- Load detection:
  - A load event is `load_1` sampled 0 while the previous sample was 1 (falling transition).
  - Holding `load_1` low produces exactly one event.
  - `count_in` is sampled on the same edge that sees `load_1`=0.
- States: IDLE, ARMED, RUN, DONE.
- Load event, any state, priority over counting:
  - Next edge: `count_out`=`count_in`, `reload_reg`=`count_in`, `load_ack`=1 for one cycle.
  - `count_in`≠0 → ARMED.
  - `count_in`=0 → IDLE, no `done`.
- ARMED or RUN with `enable`=1 and no load event:
  - `count_out`>1: decrement by 1; state RUN.
  - `count_out`=1 and AUTO_RELOAD=0: `count_out`=0, `done`=1 for one cycle, state DONE.
  - `count_out`=1 and AUTO_RELOAD=1: `count_out`=`reload_reg`, `done`=1 for one cycle, state RUN.
  - Period is N cycles for loaded value N; no zero cycle appears in auto-reload mode.
- RUN with `enable`=0: hold `count_out` and state (pause). ARMED with `enable`=0: hold.
- DONE:
  - Holds `count_out`=0 and ignores `enable`.
  - Exits only on a load event or reset.
- IDLE: ignores `enable`.
- `busy`: 1 in ARMED and RUN, 0 in IDLE and DONE.
- Latency:
  - `load_ack` and the new `count_out` appear one cycle after the edge sampling the load.
  - `done` asserts in the same cycle `count_out` shows 0 (or shows the reload value).
- Load coincident with terminal: the load wins, and `done` is not asserted.
- Arithmetic:
  - Unsigned WIDTH-bit.
  - Decrement never wraps below 0; a count of 0 in ARMED/RUN is unreachable by construction.

Decomposition:
- Package `countervar_pkg`:
  - State enum (IDLE/ARMED/RUN/DONE).
  - Default WIDTH constant.
  - `parity` function (XOR reduce).
- Sub-module `countervar_load_edge`: `load_1` history flop plus falling-edge detect, outputting a single-cycle `load_evt`; reset sets history to 1.
- Remaining FSM and datapath live in the top module.

Test Plan:
- Reset: assert `reset` for 2 cycles with `load_1`=0, `enable`=1 → `count_out`=0, `busy`=0, `load_ack`=0, `done`=0, `parity_out`=0 throughout.
- Load with `enable`=0: `load_1` low for 1 cycle, `count_in`=4'hA → next cycle `count_out`=4'hA, `load_ack`=1 for exactly 1 cycle, `busy`=1, `parity_out`=0; count holds while `enable`=0.
- Terminal stop, AUTO_RELOAD=0:
  - Load 3, `enable`=1 → `count_out` 3,2,1,0.
  - `done`=1 only in the 0 cycle, then `busy`=0.
  - Stays 0 for 10 further cycles.
- Held strobe: `load_1` low for 5 cycles, `count_in`=5 → one `load_ack` pulse.
- Mid-count reload and pause:
  - Count reaches 5, then load 9 → `count_out`=9, no `done`.
  - `enable`=0 for 3 cycles → holds 9.
  - Reset asserted mid-RUN → IDLE, all zeros next cycle.
- Auto-reload and coincident load:
  - AUTO_RELOAD=1, load 2, `enable`=1 → `count_out` 2,1,2,1,2…; `done` pulses each time 1→2.
  - Load 7 on the edge where `count_out`=1 → `count_out`=7, no `done`.
